qpp_interleave_buffer: RTL

- Frame buffer on the consumer side of the QPP address encoder (turbo-code interleaver).
- Accepts one K-symbol frame in natural order and stores it in an internal memory.
- Drives natural indices 0..K-1 into the encoder and reads memory at the returned permuted address pi(i) = (31i + 64i²) mod 4096.
- Emits the interleaved frame on a valid/ready stream.

---
 rtl/qpp_interleave_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/qpp_interleave_buffer.sv
// Consumer-side frame buffer for the QPP interleaver. A frame is written in natural
// order, then read back at the encoder-supplied permuted addresses into a small output FIFO.
module qpp_interleave_buffer #(
  parameter int K  = 4096,
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [AW-1:0] enc_idx_o,
  input  logic [AW-1:0] enc_addr_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic          busy_o
);

  localparam logic ST_FILL  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;
  localparam int   FD       = 4;
  localparam int   STAGES   = 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(K - 1);

  logic          state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [AW-1:0] enc_idx_q, enc_idx_d;
  logic          issued_all_q, issued_all_d;
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;
  logic          rd_last_q;
  logic [DW-1:0] rdata_q;

  logic [FD-1:0][DW-1:0] fifo_data_q;
  logic [FD-1:0]         fifo_last_q;
  logic [1:0]            head_q, tail_q;
  logic [2:0]            cnt_q;

  logic [DW-1:0] mem [K];
  logic [AW-1:0] mem_addr;
  logic [1:0]    inflight;
  logic [2:0]    occ;
  logic          accept, issue, push, pop, done;

  assign accept   = (state_q == ST_FILL) && in_valid_i && in_ready_q;
  assign push     = vld_pipe_q[STAGES];
  assign pop      = (cnt_q != 3'd0) && out_ready_i;
  assign done     = pop && fifo_last_q[head_q];
  // Reserve FIFO room for every read still in flight so pushes can never overflow.
  assign inflight = {1'b0, vld_pipe_q[0]} + {1'b0, vld_pipe_q[1]};
  assign occ      = cnt_q + {1'b0, inflight};
  assign issue    = (state_q == ST_DRAIN) && !issued_all_q && (occ < 3'd4);

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    enc_idx_d    = enc_idx_q;
    issued_all_d = issued_all_q;
    vld_pipe_d   = {vld_pipe_q[STAGES-1:0], issue};
    if (state_q == ST_FILL) begin
      in_ready_d = 1'b1;
      if (accept) begin
        wr_cnt_d = wr_cnt_q + AW'(1);
        if (wr_cnt_q == LAST_IDX) begin
          state_d    = ST_DRAIN;
          in_ready_d = 1'b0;
          wr_cnt_d   = '0;
          rd_cnt_d   = '0;
        end
      end
    end else begin
      if (issue) begin
        enc_idx_d = rd_cnt_q;
        rd_cnt_d  = rd_cnt_q + AW'(1);
        if (rd_cnt_q == LAST_IDX) issued_all_d = 1'b1;
      end
      if (done) begin
        state_d      = ST_FILL;
        in_ready_d   = 1'b1;
        enc_idx_d    = '0;
        rd_cnt_d     = '0;
        issued_all_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      in_ready_q   <= 1'b0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      enc_idx_q    <= '0;
      issued_all_q <= 1'b0;
      vld_pipe_q   <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      enc_idx_q    <= enc_idx_d;
      issued_all_q <= issued_all_d;
      vld_pipe_q   <= vld_pipe_d;
      rd_last_q    <= (enc_idx_q == LAST_IDX);
    end
  end

  // Single-port array: FILL owns it for writes, DRAIN for permuted reads.
  assign mem_addr = (state_q == ST_FILL) ? wr_cnt_q : enc_addr_i;

  always_ff @(posedge clk) begin
    if (accept) mem[mem_addr] <= in_data_i;
    else if (vld_pipe_q[0]) rdata_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data_q <= '0;
      fifo_last_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (push) begin
        fifo_data_q[tail_q] <= rdata_q;
        fifo_last_q[tail_q] <= rd_last_q;
        tail_q              <= tail_q + 2'd1;
      end
      if (pop) head_q <= head_q + 2'd1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign enc_idx_o   = enc_idx_q;
  assign out_valid_o = (cnt_q != 3'd0);
  assign out_data_o  = fifo_data_q[head_q];
  assign out_last_o  = out_valid_o && fifo_last_q[head_q];
  assign busy_o      = (state_q == ST_DRAIN);

endmodule
